axilite_csr_write_channel: RTL and testbench

Parametrised AXI4-Lite write-path slave for a CSR register bank. It accepts AW and W independently in either order or together, then applies a byte-strobed, bit-masked write to one of NUM_REGS registers. It returns a B response with backpressure and pulses a per-register write strobe for downstream control logic. It sits between the AXI-Lite interconnect and the coprocessor's control/config registers.

---
 rtl/axilite_csr_pkg.sv | 22 ++
 rtl/axilite_csr_reg_bank.sv | 64 ++++++
 rtl/axilite_csr_write_channel.sv | 169 ++++++++++++++++
 tb/tb_axilite_csr_write_channel.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axilite_csr_pkg.sv
// Definitions shared by the CSR AXI4-Lite write and read channels: response
// codes, the write-channel FSM encoding, and the helper for the address shift.
package axilite_csr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_e;

    // Number of low byte-address bits to drop to get a register index.
    // A 32-bit bus drops 2 bits and a 64-bit bus drops 3 bits.
    function automatic int aligned_index_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axilite_csr_reg_bank.sv
// CSR storage. Merges the strobed and bit-masked write into the selected
// register and produces a one-cycle write pulse for that register.
module axilite_csr_reg_bank #(
    parameter int                             NUM_REGS      = 4,
    parameter int                             DATA_WIDTH    = 32,
    parameter int                             IDX_W         = 2,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] WRITABLE_MASK = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_W-1:0]               idx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    // Byte strobes widened to a per-bit mask. This mask is shared by all registers.
    logic [DATA_WIDTH-1:0] lane_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{wstrb[gi]}};
        end

        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [DATA_WIDTH-1:0] REG_RESET = RESET_VALUE[gi*DATA_WIDTH +: DATA_WIDTH];
            localparam logic [DATA_WIDTH-1:0] REG_WMASK = WRITABLE_MASK[gi*DATA_WIDTH +: DATA_WIDTH];

            logic [DATA_WIDTH-1:0] value_reg;
            logic [DATA_WIDTH-1:0] value_next;
            logic [DATA_WIDTH-1:0] bit_mask;
            logic                  pulse_reg;
            logic                  hit;

            assign hit        = we && (idx == IDX_W'(gi));
            // Only bits that are both strobed and writable take the new data.
            assign bit_mask   = lane_mask & REG_WMASK;
            assign value_next = (value_reg & ~bit_mask) | (wdata & bit_mask);

            // Register storage and a pulse that fires on any addressed commit, including an all-zero strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    value_reg <= REG_RESET;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit) begin
                        value_reg <= value_next;
                    end
                end
            end

            assign regs[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
            assign wr_pulse[gi]                      = pulse_reg;
        end
    endgenerate

endmodule

// File: rtl/axilite_csr_write_channel.sv
// AXI4-Lite write channel for the CSR bank. AW and W are captured separately
// in any order. The write is then committed and one B response is returned.
// Only one write is in flight at a time.
module axilite_csr_write_channel
    import axilite_csr_pkg::*;
#(
    parameter int                             NUM_REGS      = 4,
    parameter int                             DATA_WIDTH    = 32,
    parameter int                             ADDR_SIZE     = 32,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] WRITABLE_MASK = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_SIZE-1:0]           awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int ADDR_LSB = aligned_index_shift(DATA_WIDTH);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wr_state_e state_reg, state_next;

    logic                    awready_reg, awready_next;
    logic                    wready_reg,  wready_next;
    logic                    bvalid_reg,  bvalid_next;
    logic [1:0]              bresp_reg,   bresp_next;

    logic                    aw_held_reg;
    logic                    w_held_reg;
    logic [ADDR_SIZE-1:0]    aw_addr_reg;
    logic [DATA_WIDTH-1:0]   w_data_reg;
    logic [DATA_WIDTH/8-1:0] w_strb_reg;

    logic                    aw_hs, w_hs, b_hs;
    logic                    aw_held_now, w_held_now;
    logic                    commit;
    logic [ADDR_SIZE-1:0]    word_idx;
    logic                    in_range;

    // The ready signals are high only in IDLE, so a handshake can only happen there.
    assign aw_hs       = awvalid && awready_reg;
    assign w_hs        = wvalid && wready_reg;
    assign b_hs        = bvalid_reg && bready;
    assign aw_held_now = aw_held_reg || aw_hs;
    assign w_held_now  = w_held_reg || w_hs;

    // The compare uses the full address width, so large addresses cannot alias onto a valid register.
    assign word_idx = aw_addr_reg >> ADDR_LSB;
    assign in_range = (word_idx < ADDR_SIZE'(NUM_REGS));

    // State and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= WR_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            state_reg   <= state_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            bresp_reg   <= bresp_next;
        end
    end

    // Capture the AW and W beats. The held flags clear once the response is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_addr_reg <= awaddr;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end
            if (state_reg == WR_RESP && b_hs) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WR_IDLE:   if (aw_held_now && w_held_now) state_next = WR_COMMIT;
            WR_COMMIT: state_next = WR_RESP;
            WR_RESP:   if (b_hs) state_next = WR_IDLE;
            default:   state_next = WR_IDLE;
        endcase
    end

    // Next values of the registered outputs, and the one-cycle commit strobe.
    always_comb begin
        awready_next = 1'b0;
        wready_next  = 1'b0;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        commit       = 1'b0;
        case (state_reg)
            WR_IDLE: begin
                // A ready drops on the same edge that captures its beat.
                awready_next = ~aw_held_now;
                wready_next  = ~w_held_now;
            end
            WR_COMMIT: begin
                commit      = 1'b1;
                bvalid_next = 1'b1;
                bresp_next  = in_range ? RESP_OKAY : RESP_SLVERR;
            end
            WR_RESP: begin
                if (b_hs) begin
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                end
            end
            default: begin
                awready_next = 1'b0;
                wready_next  = 1'b0;
            end
        endcase
    end

    axilite_csr_reg_bank #(
        .NUM_REGS      (NUM_REGS),
        .DATA_WIDTH    (DATA_WIDTH),
        .IDX_W         (IDX_W),
        .WRITABLE_MASK (WRITABLE_MASK),
        .RESET_VALUE   (RESET_VALUE)
    ) u_reg_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (commit && in_range),
        .idx      (word_idx[IDX_W-1:0]),
        .wdata    (w_data_reg),
        .wstrb    (w_strb_reg),
        .regs     (regs),
        .wr_pulse (wr_pulse)
    );

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;

endmodule

// File: tb/tb_axilite_csr_write_channel.sv
// Directed bench for the CSR write channel. A table of single writes is
// applied in order, followed by hand-written backpressure and reset sequences.
module tb_axilite_csr_write_channel;

    localparam logic [127:0] WMASK  = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF};
    localparam logic [127:0] RSTVAL = {32'h00000000, 32'h11223344, 32'h00000000, 32'h00000000};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [127:0] regs;
    logic [3:0]   wr_pulse;

    int checks   = 0;
    int failures = 0;

    axilite_csr_write_channel #(
        .NUM_REGS      (4),
        .DATA_WIDTH    (32),
        .ADDR_SIZE     (32),
        .WRITABLE_MASK (WMASK),
        .RESET_VALUE   (RSTVAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .regs     (regs),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        int           aw_dly;
        int           w_dly;
        logic [1:0]   resp;
        logic [3:0]   pulse;
        logic [127:0] regs_exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one write with the given AW/W start delays and bready held high. Check the
    // timing relative to the last handshake edge T: bvalid rises at T+1 and drops at T+2.
    task automatic run_vec(input int n, input vec_t v);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        cyc = 0; aw_done = 0; w_done = 0;
        awaddr = v.addr; wdata = v.data; wstrb = v.strb;
        while (!(aw_done && w_done) && cyc < 20) begin
            awvalid = !aw_done && (cyc >= v.aw_dly);
            wvalid  = !w_done && (cyc >= v.w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            cyc++;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            if (w_done && !aw_done) chk($sformatf("v%0d_wready_held", n), {127'b0, wready}, 128'd0);
            if (aw_done && !w_done) chk($sformatf("v%0d_awready_held", n), {127'b0, awready}, 128'd0);
        end
        awvalid = 0; wvalid = 0;
        chk($sformatf("v%0d_handshake_timeout", n), {127'b0, aw_done && w_done}, 128'd1);
        chk($sformatf("v%0d_T_bvalid", n), {127'b0, bvalid}, 128'd0);
        chk($sformatf("v%0d_T_ready", n), {126'b0, awready, wready}, 128'd0);
        tick();
        chk($sformatf("v%0d_bvalid", n), {127'b0, bvalid}, 128'd1);
        chk($sformatf("v%0d_bresp", n), {126'b0, bresp}, {126'b0, v.resp});
        chk($sformatf("v%0d_pulse", n), {124'b0, wr_pulse}, {124'b0, v.pulse});
        chk($sformatf("v%0d_regs", n), regs, v.regs_exp);
        $display("write %0d addr=%08h data=%08h strb=%h bresp=%0d pulse=%b", n, v.addr, v.data, v.strb, bresp, wr_pulse);
        tick();
        chk($sformatf("v%0d_bvalid_drop", n), {127'b0, bvalid}, 128'd0);
        chk($sformatf("v%0d_pulse_drop", n), {124'b0, wr_pulse}, 128'd0);
        chk($sformatf("v%0d_ready_back", n), {126'b0, awready, wready}, 128'd3);
    endtask

    initial begin
        bit saw_b;

        vecs[0] = '{32'h00000004, 32'hDEADBEEF, 4'hF, 0, 0, 2'd0, 4'b0010,
                    {32'h00000000, 32'h11223344, 32'hDEADBEEF, 32'h00000000}};
        vecs[1] = '{32'h00000008, 32'h000000AA, 4'h1, 3, 0, 2'd0, 4'b0100,
                    {32'h00000000, 32'h112233AA, 32'hDEADBEEF, 32'h00000000}};
        vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 4'hF, 0, 0, 2'd0, 4'b0001,
                    {32'h00000000, 32'h112233AA, 32'hDEADBEEF, 32'h0000FFFF}};
        vecs[3] = '{32'h00000010, 32'h12345678, 4'hF, 0, 0, 2'd2, 4'b0000,
                    {32'h00000000, 32'h112233AA, 32'hDEADBEEF, 32'h0000FFFF}};
        vecs[4] = '{32'h0000000E, 32'hCAFEF00D, 4'hC, 1, 2, 2'd0, 4'b1000,
                    {32'hCAFE0000, 32'h112233AA, 32'hDEADBEEF, 32'h0000FFFF}};
        vecs[5] = '{32'h0000000C, 32'hFFFFFFFF, 4'h0, 0, 0, 2'd0, 4'b1000,
                    {32'hCAFE0000, 32'h112233AA, 32'hDEADBEEF, 32'h0000FFFF}};
        vecs[6] = '{32'hFFFFFFFC, 32'h87654321, 4'hF, 2, 0, 2'd2, 4'b0000,
                    {32'hCAFE0000, 32'h112233AA, 32'hDEADBEEF, 32'h0000FFFF}};
        vecs[7] = '{32'h00000004, 32'h00FF00FF, 4'h5, 0, 0, 2'd0, 4'b0010,
                    {32'hCAFE0000, 32'h112233AA, 32'hDEFFBEFF, 32'h0000FFFF}};
        vecs[8] = '{32'h00000000, 32'h12345678, 4'hF, 0, 0, 2'd0, 4'b0001,
                    {32'hCAFE0000, 32'h112233AA, 32'hDEFFBEFF, 32'h00005678}};

        rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
        tick(); tick(); tick();
        chk("rst_regs", regs, RSTVAL);
        chk("rst_outs", {121'b0, awready, wready, bvalid, wr_pulse}, 128'd0);
        chk("rst_bresp", {126'b0, bresp}, 128'd0);
        rst = 0;
        tick();
        chk("post_rst_ready", {126'b0, awready, wready}, 128'd3);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Backpressure: the B response is stalled while a second write waits.
        bready = 0;
        awaddr = 32'h8; wdata = 32'h55667788; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        chk("bp_first_taken", {126'b0, awready, wready}, 128'd0);
        awaddr = 32'hC; wdata = 32'h01020304; wstrb = 4'hF;
        tick();
        chk("bp_bvalid", {127'b0, bvalid}, 128'd1);
        chk("bp_regs1", regs, {32'hCAFE0000, 32'h55667788, 32'hDEFFBEFF, 32'h00005678});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_stall%0d", i), {123'b0, bvalid, bresp, awready, wready}, {123'b0, 1'b1, 2'b00, 2'b00});
        end
        $display("write bp1 addr=00000008 stalled bvalid=%b bresp=%0d", bvalid, bresp);
        chk("bp_regs_stall", regs, {32'hCAFE0000, 32'h55667788, 32'hDEFFBEFF, 32'h00005678});
        bready = 1;
        tick();
        chk("bp_release", {125'b0, bvalid, awready, wready}, {125'b0, 3'b011});
        tick();
        chk("bp_second_taken", {126'b0, awready, wready}, 128'd0);
        awvalid = 0; wvalid = 0;
        tick();
        chk("bp2_bvalid", {125'b0, bvalid, bresp}, {125'b0, 3'b100});
        chk("bp2_pulse", {124'b0, wr_pulse}, {124'b0, 4'b1000});
        chk("bp2_regs", regs, {32'h01020304, 32'h55667788, 32'hDEFFBEFF, 32'h00005678});
        $display("write bp2 addr=0000000C bresp=%0d pulse=%b", bresp, wr_pulse);
        tick();
        chk("bp2_bvalid_drop", {127'b0, bvalid}, 128'd0);

        // Reset during COMMIT drops the write and its response.
        bready = 0;
        awaddr = 32'h0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        rst = 1;
        tick();
        chk("midrst_regs", regs, RSTVAL);
        chk("midrst_outs", {121'b0, awready, wready, bvalid, wr_pulse}, 128'd0);
        rst = 0; bready = 1;
        saw_b = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bvalid) saw_b = 1;
        end
        chk("midrst_no_b", {127'b0, saw_b}, 128'd0);
        chk("midrst_ready", {126'b0, awready, wready}, 128'd3);
        $display("write rst addr=00000000 dropped bvalid_seen=%b", saw_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
